// File: rtl/muldiv_pkg.sv
// Shared constants, state type and helpers for the Z-register multiply/divide engine.
// MULDIV_RADIX4_EN selects radix-4 Booth multiply (16 iterations instead of 32).
package muldiv_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    localparam logic [5:0] ITER_R2 = 6'd32;
    localparam logic [5:0] ITER_R4 = 6'd16;

`ifdef MULDIV_RADIX4_EN
    localparam logic [5:0] ITER_MUL = ITER_R4;
`else
    localparam logic [5:0] ITER_MUL = ITER_R2;
`endif
    localparam logic [5:0] ITER_DIV = ITER_R2;

    // Two's complement magnitude; the most negative value maps to itself, read as unsigned.
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? -x : x;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of Booth multiply or restoring divide on the {acc, low, qbit} register set.
// MULDIV_RADIX4_EN switches the multiply path to radix-4 recoding.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic                  is_div,
    input  logic [DATA_WIDTH+1:0] acc,
    input  logic [DATA_WIDTH-1:0] low,
    input  logic                  qbit,
    input  logic [DATA_WIDTH-1:0] mcand,
    output logic [DATA_WIDTH+1:0] acc_next,
    output logic [DATA_WIDTH-1:0] low_next,
    output logic                  qbit_next
);

    localparam int W = DATA_WIDTH;

    logic [W+1:0] m1;
    logic [W+1:0] sum;
    logic [W+1:0] shifted;
    logic [W+1:0] trial;
`ifdef MULDIV_RADIX4_EN
    logic [W+1:0] m2;
`endif

    always_comb begin
        m1        = {{2{mcand[W-1]}}, mcand};
`ifdef MULDIV_RADIX4_EN
        m2        = {m1[W:0], 1'b0};
`endif
        sum       = acc;
        shifted   = {1'b0, acc[W-1:0], low[W-1]};
        trial     = shifted - {2'b00, mcand};
        acc_next  = acc;
        low_next  = low;
        qbit_next = qbit;

        if (is_div) begin
            // Restoring step: keep the trial difference only when it did not go negative.
            if (!trial[W+1]) begin
                acc_next = trial;
                low_next = {low[W-2:0], 1'b1};
            end else begin
                acc_next = shifted;
                low_next = {low[W-2:0], 1'b0};
            end
            qbit_next = 1'b0;
        end else begin
`ifdef MULDIV_RADIX4_EN
            case ({low[1:0], qbit})
                3'b001, 3'b010: sum = acc + m1;
                3'b011:         sum = acc + m2;
                3'b100:         sum = acc - m2;
                3'b101, 3'b110: sum = acc - m1;
                default:        sum = acc;
            endcase
            acc_next  = {{2{sum[W+1]}}, sum[W+1:2]};
            low_next  = {sum[1:0], low[W-1:2]};
            qbit_next = low[1];
`else
            case ({low[0], qbit})
                2'b01:   sum = acc + m1;
                2'b10:   sum = acc - m1;
                default: sum = acc;
            endcase
            acc_next  = {sum[W+1], sum[W+1:1]};
            low_next  = {sum[0], low[W-1:1]};
            qbit_next = low[0];
`endif
        end
    end

endmodule

// File: rtl/z_muldiv_unit.sv
// Multi-cycle signed multiply/divide feeding the Z register high/low halves.
// MULDIV_RADIX4_EN shortens multiply to 16 iterations; divide always takes 32.
module z_muldiv_unit
    import muldiv_pkg::*;
(
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic [4:0]            op_code,
    input  logic [DATA_WIDTH-1:0] BusMuxInY,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] Zhighout,
    output logic [DATA_WIDTH-1:0] Zlowout
);

    localparam int W = DATA_WIDTH;

    state_t         state;
    logic [5:0]     count;
    logic           op_div;
    logic           neg_q;
    logic           neg_r;
    logic [W+1:0]   acc;
    logic [W-1:0]   low;
    logic           qbit;
    logic [W-1:0]   mcand;
    logic [W+1:0]   acc_next;
    logic [W-1:0]   low_next;
    logic           qbit_next;
    logic [W-1:0]   quot;
    logic [W-1:0]   rem;
    logic           valid_op;
    logic           accept;

    muldiv_step u_step (
        .is_div    (op_div),
        .acc       (acc),
        .low       (low),
        .qbit      (qbit),
        .mcand     (mcand),
        .acc_next  (acc_next),
        .low_next  (low_next),
        .qbit_next (qbit_next)
    );

    assign quot     = neg_q ? -low_next : low_next;
    assign rem      = neg_r ? -acc_next[W-1:0] : acc_next[W-1:0];
    assign valid_op = (op_code == OP_MUL) || (op_code == OP_DIV);
    assign accept   = start && valid_op && (state != RUN);

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            Zhighout    <= '0;
            Zlowout     <= '0;
            count       <= '0;
            op_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            acc         <= '0;
            low         <= '0;
            qbit        <= 1'b0;
            mcand       <= '0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (accept) begin
                        div_by_zero <= 1'b0;
                        op_div      <= (op_code == OP_DIV);
                        acc         <= '0;
                        qbit        <= 1'b0;
                        // Divide iterates on magnitudes; signs are reapplied when the result is stored.
                        if (op_code == OP_DIV) begin
                            low   <= magnitude(BusMuxInY);
                            mcand <= magnitude(BusMuxOut);
                            neg_q <= BusMuxInY[W-1] ^ BusMuxOut[W-1];
                            neg_r <= BusMuxInY[W-1];
                            count <= ITER_DIV;
                        end else begin
                            low   <= BusMuxOut;
                            mcand <= BusMuxInY;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            count <= ITER_MUL;
                        end
                        if ((op_code == OP_DIV) && (BusMuxOut == '0)) begin
                            state       <= FIN;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            Zhighout    <= BusMuxInY;
                            Zlowout     <= '1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    low   <= low_next;
                    qbit  <= qbit_next;
                    count <= count - 6'd1;
                    // The last iteration's result goes straight to the Z halves on the way into FIN.
                    if (count == 6'd1) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (op_div) begin
                            Zhighout <= rem;
                            Zlowout  <= quot;
                        end else begin
                            Zhighout <= acc_next[W-1:0];
                            Zlowout  <= low_next;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/z_muldiv_unit.md
Name: z_muldiv_unit

Overview:
- Multi-cycle signed multiply/divide engine sharing the ALU's operand inputs (Y register value and bus value) and its 5-bit operation encoding.
- Produces the 64-bit result consumed by the Z register as separate high/low halves, in place of the combinational ALU path for MUL and DIV.
- Uses a start/busy/done handshake so the control unit holds the datapath until the Z register load.

Parameters:
- DATA_WIDTH, 32, operand width; results are 2*DATA_WIDTH split into high/low halves.
- OP_MUL, 5'b01110, op_code value selecting multiply.
- OP_DIV, 5'b01111, op_code value selecting divide.

Ports:
- clock  input  1  rising-edge clock
- clear  input  1  synchronous active-high reset
- start  input  1  request pulse; sampled only when busy=0
- op_code  input  5  operation select (same encoding as the ALU control)
- BusMuxInY  input  DATA_WIDTH  operand A (multiplicand / dividend)
- BusMuxOut  input  DATA_WIDTH  operand B (multiplier / divisor)
- busy  output  1  iteration in progress
- done  output  1  one-cycle pulse; result valid
- div_by_zero  output  1  sticky flag for the last completed operation
- Zhighout  output  DATA_WIDTH  product[63:32] / remainder
- Zlowout  output  DATA_WIDTH  product[31:0] / quotient

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous and active-high (clear).
- Reset values: clear=1 at a clock edge forces state IDLE and sets busy, done, div_by_zero, Zhighout and Zlowout to 0. Clear takes priority over start. Clear during RUN aborts the operation with no done pulse and no result update.
- FSM states: IDLE, RUN, FIN.
  - IDLE: start=1 with op_code in {OP_MUL, OP_DIV} latches both operands and op_code, loads the iteration counter with 32 and goes to RUN.
  - IDLE: start with any other op_code is ignored; state stays IDLE.
  - RUN: one iteration per cycle. The counter decrements; at 0 the state goes to FIN.
  - FIN: done=1 for exactly one cycle; Zhighout/Zlowout update on entry to FIN. Next state is IDLE. A valid start seen in FIN is accepted the same way as in IDLE (back-to-back).
- Latency: start is sampled at cycle 0. busy=1 for cycles 1..32. done=1 in cycle 33. busy=0 whenever done=1.
- Result hold: Zhighout/Zlowout hold their value between completions. Intermediate accumulator values are never visible on them. Operand changes after cycle 0 have no effect.
- start while busy=1 is ignored; it is neither queued nor an error.
- Multiply: radix-2 Booth, signed two's complement, full 64-bit exact product. No overflow is possible.
- Divide: signed restoring division on magnitudes, then sign correction.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend; |remainder| < |divisor|.
  - Zlowout = quotient, Zhighout = remainder.
- Divide by zero (divisor 0 at the start sample):
  - No iterations. FIN is reached in cycle 1, so done=1 in cycle 1.
  - Zlowout=32'hFFFFFFFF, Zhighout=dividend, div_by_zero=1.
- div_by_zero clears on the next accepted start.
- Overflow case 32'h80000000 / 32'hFFFFFFFF: quotient wraps to 32'h80000000, remainder 0, div_by_zero=0.

Optional Feature:
- Macro: MULDIV_RADIX4_EN.
- Defined: multiply uses radix-4 Booth recoding with 16 RUN cycles, so done=1 in cycle 17. Divide is unchanged.
- Undefined: radix-2 multiply, 32 RUN cycles.
- Results are bit-identical in both builds.

Decomposition:
- Shared package muldiv_pkg holds:
  - DATA_WIDTH
  - OP_MUL/OP_DIV constants, shared with the ALU decode
  - FSM state typedef (IDLE/RUN/FIN)
  - iteration count constants (32, and 16 for radix-4)
- Sub-module muldiv_step: combinational single-iteration datapath (Booth add/sub/shift, or restoring subtract/shift) selected by the latched op. The top module keeps the FSM, counter, operand latches and output registers.

Test Plan:
- MUL 7 x -3 (32'h00000007, 32'hFFFFFFFD) -> done in cycle 33; Zhighout=32'hFFFFFFFF, Zlowout=32'hFFFFFFEB; busy high exactly 32 cycles.
- MUL 32'h7FFFFFFF x 32'h7FFFFFFF -> Zhighout=32'h3FFFFFFF, Zlowout=32'h00000001. MUL 32'h80000000 x 32'h80000000 -> Zhighout=32'h40000000, Zlowout=0.
- DIV -17 / 5 -> Zlowout=32'hFFFFFFFD (-3), Zhighout=32'hFFFFFFFE (-2). DIV 17 / -5 -> Zlowout=32'hFFFFFFFD, Zhighout=32'h00000002.
- DIV 42 / 0 -> done in cycle 1, div_by_zero=1, Zlowout=32'hFFFFFFFF, Zhighout=32'h0000002A. Next DIV 10/3 -> div_by_zero=0, Zlowout=3, Zhighout=1.
- DIV 32'h80000000 / 32'hFFFFFFFF -> Zlowout=32'h80000000, Zhighout=0. Also start with op_code=5'b00011 -> no busy, no done.
- Start MUL 5x6; at cycle 10 pulse start (ignored), at cycle 15 assert clear -> no done, outputs 0, IDLE. Restart 5x6 -> Zlowout=30 in cycle 33.
